// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: control/data inputs and registered outputs.
// The master side drives the controls and the slave side is the shift register.
interface universal_shift_register_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [2:0]       mode;
    logic             data_in;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic [CW-1:0]    bit_count;
    logic             word_done;

    modport master (
        output en, mode, data_in, par_in,
        input  data_out, serial_out, bit_count, word_done
    );

    modport slave (
        input  en, mode, data_in, par_in,
        output data_out, serial_out, bit_count, word_done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: shift/rotate in both directions, parallel load,
// clear, registered serial output and a per-word bit counter with a one-cycle done pulse.
module universal_shift_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                        clk,
    input logic                        rst,
    universal_shift_register_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] r_data;
    logic             r_serial;
    logic [CW-1:0]    r_count;
    logic             r_word_done;

    mode_e w_mode;
    logic  w_shift;
    logic  w_wrap;
    logic  w_count_clr;

    assign w_mode      = mode_e'(bus.mode);
    assign w_shift     = bus.en && (w_mode == MODE_SHL || w_mode == MODE_SHR);
    assign w_wrap      = w_shift && (r_count == LAST_BIT);
    assign w_count_clr = bus.en && (w_mode == MODE_LOAD || w_mode == MODE_CLEAR);

    // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data      <= RESET_VALUE;
            r_serial    <= 1'b0;
            r_count     <= '0;
            r_word_done <= 1'b0;
        end else begin
            // Only a wrapping shift raises the pulse; every other edge drops it.
            r_word_done <= w_wrap;

            if (bus.en) begin
                case (w_mode)
                    MODE_SHL: begin
                        r_data   <= {r_data[WIDTH-2:0], bus.data_in};
                        r_serial <= r_data[WIDTH-1];
                    end
                    MODE_SHR: begin
                        r_data   <= {bus.data_in, r_data[WIDTH-1:1]};
                        r_serial <= r_data[0];
                    end
                    MODE_ROL: begin
                        r_data   <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                        r_serial <= r_data[WIDTH-1];
                    end
                    MODE_ROR: begin
                        r_data   <= {r_data[0], r_data[WIDTH-1:1]};
                        r_serial <= r_data[0];
                    end
                    MODE_LOAD:  r_data <= bus.par_in;
                    MODE_CLEAR: begin
                        r_data   <= '0;
                        r_serial <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (w_shift) begin
                r_count <= w_wrap ? '0 : r_count + CW'(1);
            end else if (w_count_clr) begin
                r_count <= '0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.serial_out = r_serial;
    assign bus.bit_count  = r_count;
    assign bus.word_done  = r_word_done;
endmodule
